mcp_instr_fetch_reg: RTL

Instruction fetch and instruction register stage of the MIPS multicycle processor. On a request from the control unit it issues one read to instruction memory at the current PC, waits for the memory acknowledge, and latches the returned word. It then holds the word stable for the decode, register-read and execute cycles. The latched word is sliced into the standard MIPS fields: the 16-bit immediate feeds the sign-extension unit directly downstream, and the remaining fields feed the control unit and register file.

---
 rtl/mcp_instr_fetch_reg.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mcp_instr_fetch_reg.sv
// Multicycle MIPS instruction fetch + instruction register: one memory read per request, IR held between fetches.
// Optional fetch timeout with sticky error state is enabled by defining MCP_FETCH_TIMEOUT_EN.
module mcp_instr_fetch_reg #(
   parameter int unsigned WL      = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          fetch_start,
   input  logic [WL-1:0] PC,
   output logic          mem_req,
   output logic [WL-1:0] mem_addr,
   input  logic [WL-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [WL-1:0] IR,
   output logic [5:0]    Opcode,
   output logic [4:0]    Rs,
   output logic [4:0]    Rt,
   output logic [4:0]    Rd,
   output logic [4:0]    Shamt,
   output logic [5:0]    Funct,
   output logic [15:0]   Imm,
   output logic [25:0]   Jaddr,
   output logic          ir_valid,
   output logic          busy,
   output logic          fetch_err
);

   // Elaboration-time parameter sanity checks
   if (WL < 32) begin : g_bad_wl
      $error("mcp_instr_fetch_reg: WL must be at least 32");
   end
   if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
      $error("mcp_instr_fetch_reg: TIMEOUT must be in 1..255");
   end

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_WAIT = 2'b01;
`ifdef MCP_FETCH_TIMEOUT_EN
   localparam logic [1:0] S_ERR  = 2'b10;
   localparam int unsigned CW    = $clog2(TIMEOUT + 1);

   logic [CW-1:0] r_tmo;
   logic [CW-1:0] w_tmo_nxt;
   logic          r_err;
   logic          w_err_nxt;
`endif

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [WL-1:0] r_ir;
   logic [WL-1:0] w_ir_nxt;
   logic [WL-1:0] r_addr;
   logic [WL-1:0] w_addr_nxt;
   logic          r_valid;
   logic          w_valid_nxt;
   logic          r_req;
   logic          r_busy;

   // Next-state and next-register-value logic
   always_comb begin
      w_state_nxt = r_state;
      w_ir_nxt    = r_ir;
      w_addr_nxt  = r_addr;
      w_valid_nxt = r_valid;
`ifdef MCP_FETCH_TIMEOUT_EN
      w_tmo_nxt   = r_tmo;
      w_err_nxt   = r_err;
`endif
      case (r_state)
         S_IDLE: begin
            if (fetch_start) begin
               w_state_nxt = S_WAIT;
               w_addr_nxt  = PC;
               w_valid_nxt = 1'b0;
`ifdef MCP_FETCH_TIMEOUT_EN
               w_tmo_nxt   = '0;
`endif
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
               w_ir_nxt    = mem_rdata;
               w_valid_nxt = 1'b1;
            end
`ifdef MCP_FETCH_TIMEOUT_EN
            else if (r_tmo == CW'(TIMEOUT - 1)) begin
               // Edge ending the last allowed request cycle
               w_state_nxt = S_ERR;
               w_valid_nxt = 1'b0;
               w_err_nxt   = 1'b1;
            end else begin
               w_tmo_nxt   = r_tmo + CW'(1);
            end
`endif
         end
`ifdef MCP_FETCH_TIMEOUT_EN
         S_ERR: begin
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b1;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_ir    <= '0;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
`ifdef MCP_FETCH_TIMEOUT_EN
         r_tmo   <= '0;
         r_err   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ir    <= w_ir_nxt;
         r_addr  <= w_addr_nxt;
         r_valid <= w_valid_nxt;
         r_req   <= (w_state_nxt == S_WAIT);
         r_busy  <= (w_state_nxt == S_WAIT);
`ifdef MCP_FETCH_TIMEOUT_EN
         r_tmo   <= w_tmo_nxt;
         r_err   <= w_err_nxt;
`endif
      end
   end

   assign mem_req  = r_req;
   assign busy     = r_busy;
   assign mem_addr = r_addr;
   assign IR       = r_ir;
   assign ir_valid = r_valid;
`ifdef MCP_FETCH_TIMEOUT_EN
   assign fetch_err = r_err;
`else
   assign fetch_err = 1'b0;
`endif

   // Field slices are combinational views of IR
   assign Opcode = r_ir[31:26];
   assign Rs     = r_ir[25:21];
   assign Rt     = r_ir[20:16];
   assign Rd     = r_ir[15:11];
   assign Shamt  = r_ir[10:6];
   assign Funct  = r_ir[5:0];
   assign Imm    = r_ir[15:0];
   assign Jaddr  = r_ir[25:0];

endmodule
